uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx.sv | 111 +++++++++++
 rtl/uart_tx_fifo.sv | 103 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: frame width and FSM state encodings.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } feed_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 serializer: start bit, DATA_BITS data bits LSB first, stop bit, each CLKS_PER_BIT clocks.
// Line and busy leave through output registers, so they stay aligned with each other.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_dv_i,
    input  logic [DATA_BITS-1:0] tx_byte_i,
    output logic                 tx_o,
    output logic                 tx_busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 line_d, tx_q;
    logic                 busy_d, busy_q;
    logic                 bit_done;

    assign bit_done  = (cnt_q == CNT_LAST);
    assign tx_o      = tx_q;
    assign tx_busy_o = busy_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= line_d;
            busy_q  <= busy_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        unique case (state_q)
            TX_IDLE: begin
                if (tx_dv_i) begin
                    state_d = TX_START;
                    cnt_d   = '0;
                    idx_d   = '0;
                    shift_d = tx_byte_i;
                end
            end
            TX_START: begin
                if (bit_done) begin
                    state_d = TX_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d = TX_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (bit_done) begin
                    state_d = TX_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        line_d = 1'b1;
        busy_d = 1'b1;
        unique case (state_q)
            TX_IDLE:  busy_d = 1'b0;
            TX_START: line_d = 1'b0;
            TX_DATA:  line_d = shift_q[0];
            default:  line_d = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a uart_tx serializer; a small feeder FSM hands one byte at a time
// to the serializer and waits for its busy pulse to rise and fall before issuing the next.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int DEPTH        = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [DATA_BITS-1:0]   in_byte,
    output logic                   in_ready,
    output logic                   tx,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;
    feed_state_e          state_q, state_d;
    logic                 push, pop;
    logic                 tx_dv_r;
    logic [DATA_BITS-1:0] tx_byte_r;
    logic                 tx_busy;

    assign in_ready   = (count_q != FULL);
    assign push       = in_valid && in_ready && !reset;
    assign fifo_count = count_q;
    assign busy       = (count_q != '0) || (state_q != IDLE) || tx_busy;

    // NOTE: the data array carries no reset; pointers and count alone define its contents,
    // which keeps it mappable to distributed RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_byte;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tx_dv_r   <= 1'b0;
            tx_byte_r <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            tx_dv_r <= pop;
            if (pop) tx_byte_r <= mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (count_q != '0) state_d = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy)       state_d = WAIT_DONE;
            WAIT_DONE: if (!tx_busy)      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Popping only from IDLE guarantees the serializer never sees a request while busy.
    always_comb begin
        pop = (state_q == IDLE) && (count_q != '0);
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk      (clk),
        .reset    (reset),
        .tx_dv_i  (tx_dv_r),
        .tx_byte_i(tx_byte_r),
        .tx_o     (tx),
        .tx_busy_o(tx_busy)
    );

endmodule
